m_fetch_unit: RTL and testbench

M_FETCH_UNIT -- requirements
Module: m_fetch_unit

---
 rtl/m_fetch_pkg.sv | 23 ++
 rtl/m_fetch_fifo.sv | 46 ++++
 rtl/m_fetch_unit.sv | 97 +++++++++
 tb/tb_m_fetch_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/m_fetch_pkg.sv
// Shared types and sizing for the instruction fetch unit and its output queue.
package m_fetch_pkg;

    localparam int FETCH_FIFO_DEPTH = 2;
    localparam int FETCH_CNT_W      = $clog2(FETCH_FIFO_DEPTH + 1);
    localparam int FETCH_IDX_W      = $clog2(FETCH_FIFO_DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/m_fetch_fifo.sv
// Small shift-style queue between instruction memory and decode; head is always slot 0.
module m_fetch_fifo
    import m_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  fetch_entry_t           i_push_data,
    input  logic                   i_pop,
    output fetch_entry_t           o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [FETCH_CNT_W-1:0] o_count
);

    fetch_entry_t           r_mem [FETCH_FIFO_DEPTH];
    logic [FETCH_CNT_W-1:0] r_count;
    logic                   w_pop;
    logic [FETCH_IDX_W-1:0] w_wr_idx;
    logic [FETCH_CNT_W-1:0] w_count_nxt;

    // A flush empties the queue but still accepts a push into slot 0 in the same cycle.
    assign w_pop       = i_pop && !i_flush && !o_empty;
    assign w_wr_idx    = i_flush ? '0 : FETCH_IDX_W'(r_count - FETCH_CNT_W'(w_pop));
    assign w_count_nxt = i_flush ? FETCH_CNT_W'(i_push)
                                 : r_count + FETCH_CNT_W'(i_push) - FETCH_CNT_W'(w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            for (int i = 0; i < FETCH_FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_pop)
                for (int i = 0; i < FETCH_FIFO_DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
            if (i_push) r_mem[w_wr_idx] <= i_push_data;
        end
    end

    assign o_head  = r_mem[0];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FETCH_CNT_W'(FETCH_FIFO_DEPTH));

endmodule

// File: rtl/m_fetch_unit.sv
// Sequential instruction fetch with one-cycle memory, 2-entry output queue and redirect handling.
module m_fetch_unit
    import m_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault
);

    localparam logic [FETCH_CNT_W:0] OCC_MAX = (FETCH_CNT_W+1)'(FETCH_FIFO_DEPTH);

    fetch_state_t           r_state, w_state_nxt;
    logic [31:0]            r_pc;
    logic                   r_inflight;
    logic [31:0]            r_inflight_pc;

    fetch_entry_t           w_head, w_push_data;
    logic                   w_full, w_empty, w_pop, w_push, w_flush, w_issue;
    logic [FETCH_CNT_W-1:0] w_count;
    logic [FETCH_CNT_W:0]   w_occ;

    assign w_pop = !w_empty && out_ready;
    assign w_occ = {1'b0, w_count} + {{FETCH_CNT_W{1'b0}}, r_inflight};

    // Issue is gated on reset so nothing is requested while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        w_push      = 1'b0;
        w_push_data = '{instr: imem_instr, pc: r_inflight_pc, fault: 1'b0};
        w_issue     = 1'b0;
        if (redirect_valid) begin
            w_flush = 1'b1;
            if (is_misaligned(redirect_pc)) begin
                w_push      = 1'b1;
                w_push_data = '{instr: '0, pc: redirect_pc, fault: 1'b1};
                w_state_nxt = HALT;
            end else begin
                w_state_nxt = RUN;
            end
        end else begin
            w_push = r_inflight && (!w_full || w_pop);
            if (r_state == RUN)
                w_issue = reset && ((w_occ < OCC_MAX) || (w_occ == OCC_MAX && w_pop));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_VECTOR;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_inflight_pc <= r_pc;
            if (redirect_valid) r_pc <= redirect_pc;
            else if (w_issue)   r_pc <= r_pc + 32'd4;
        end
    end

    m_fetch_fifo u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (w_flush),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;
    assign out_valid = !w_empty;
    assign out_instr = w_empty ? '0 : w_head.instr;
    assign out_pc    = w_empty ? '0 : w_head.pc;
    assign out_fault = w_empty ? 1'b0 : w_head.fault;

endmodule

// File: tb/tb_m_fetch_unit.sv
// Directed bench for m_fetch_unit: sequential fetch, backpressure, redirects, faults and reset.
module tb_m_fetch_unit;

    localparam logic [31:0] TAG = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr = 32'hDEAD_BEEF;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_fault;

    int n_chk = 0;
    int n_err = 0;

    m_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_fault      (out_fault)
    );

    always #5 clk = ~clk;

    // Registered memory: word is the address tagged with a constant, one cycle after issue.
    always @(posedge clk) imem_instr <= imem_req ? (imem_addr ^ TAG) : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        @(posedge clk);
        #2;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic fault);
        chk({tag, "_vld"},   32'(out_valid), 32'd1);
        chk({tag, "_pc"},    out_pc, pc);
        chk({tag, "_instr"}, out_instr, instr);
        chk({tag, "_fault"}, 32'(out_fault), 32'(fault));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held: everything quiet.
        run_cycle(1'b0, '0, 1'b1);
        chk("rst_vld",   32'(out_valid), 32'd0);
        chk("rst_req",   32'(imem_req),  32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_pc",    out_pc,    32'd0);
        chk("rst_fault", 32'(out_fault), 32'd0);

        // Release and stream with out_ready=1.
        for (int k = 0; k < 8; k++) begin
            run_cycle(1'b0, '0, 1'b1);
            if (k == 0) begin
                reset = 1'b1;
                #1;
            end
            chk("seq_req",  32'(imem_req), 32'd1);
            chk("seq_addr", imem_addr, 32'(4 * k));
            chk("seq_vld",  32'(out_valid), 32'(k >= 2));
            if (k >= 2) chk_head("seq", 32'(4 * (k - 2)), 32'(4 * (k - 2)) ^ TAG, 1'b0);
        end

        // Backpressure: issue stops, head holds.
        for (int i = 0; i < 10; i++) begin
            run_cycle(1'b0, '0, 1'b0);
            chk("bp_req", 32'(imem_req), 32'd0);
            chk_head("bp_hold", 32'h18, 32'h18 ^ TAG, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0, '0, 1'b1);
            chk("bp_req_on", 32'(imem_req), 32'd1);
            chk("bp_addr",   imem_addr, 32'(32 + 4 * i));
            chk_head("bp_drain", 32'(24 + 4 * i), 32'(24 + 4 * i) ^ TAG, 1'b0);
        end

        // Redirect with a queued entry and a fetch in flight.
        run_cycle(1'b1, 32'h8000_0000, 1'b1);
        chk("rd_req_sup", 32'(imem_req), 32'd0);
        run_cycle(1'b0, '0, 1'b1);
        chk("rd_n1_vld",  32'(out_valid), 32'd0);
        chk("rd_n1_addr", imem_addr, 32'h8000_0000);
        chk("rd_n1_req",  32'(imem_req), 32'd1);
        run_cycle(1'b0, '0, 1'b1);
        chk("rd_n2_vld",  32'(out_valid), 32'd0);
        chk("rd_n2_addr", imem_addr, 32'h8000_0004);
        run_cycle(1'b0, '0, 1'b1);
        chk_head("rd_n3", 32'h8000_0000, 32'h8000_0000 ^ TAG, 1'b0);
        run_cycle(1'b0, '0, 1'b1);
        chk_head("rd_n4", 32'h8000_0004, 32'h8000_0004 ^ TAG, 1'b0);

        // Fill the queue, then misaligned redirect.
        run_cycle(1'b0, '0, 1'b0);
        chk("mis_fill_req", 32'(imem_req), 32'd0);
        chk_head("mis_fill", 32'h8000_0008, 32'h8000_0008 ^ TAG, 1'b0);
        run_cycle(1'b1, 32'h8000_0002, 1'b0);
        chk("mis_req", 32'(imem_req), 32'd0);
        run_cycle(1'b0, '0, 1'b0);
        chk_head("mis_ent", 32'h8000_0002, 32'd0, 1'b1);
        chk("mis_halt_req", 32'(imem_req), 32'd0);
        run_cycle(1'b0, '0, 1'b1);
        chk_head("mis_pop", 32'h8000_0002, 32'd0, 1'b1);
        run_cycle(1'b0, '0, 1'b1);
        chk("halt_vld", 32'(out_valid), 32'd0);
        chk("halt_req", 32'(imem_req),  32'd0);
        run_cycle(1'b1, 32'h0000_0101, 1'b1);
        chk("halt_mis_req", 32'(imem_req), 32'd0);
        run_cycle(1'b0, '0, 1'b1);
        chk_head("halt_mis", 32'h0000_0101, 32'd0, 1'b1);
        chk("halt_mis_req2", 32'(imem_req), 32'd0);
        run_cycle(1'b0, '0, 1'b1);
        chk("halt_vld2", 32'(out_valid), 32'd0);
        chk("halt_req2", 32'(imem_req),  32'd0);
        run_cycle(1'b1, 32'h0000_0040, 1'b1);
        chk("resume_sup", 32'(imem_req), 32'd0);
        run_cycle(1'b0, '0, 1'b1);
        chk("resume_req",  32'(imem_req), 32'd1);
        chk("resume_addr", imem_addr, 32'h40);
        chk("resume_vld",  32'(out_valid), 32'd0);
        run_cycle(1'b0, '0, 1'b1);
        chk("resume_addr2", imem_addr, 32'h44);
        run_cycle(1'b0, '0, 1'b1);
        chk_head("resume", 32'h40, 32'h40 ^ TAG, 1'b0);

        // PC wrap past the top of the address space.
        run_cycle(1'b1, 32'hFFFF_FFF8, 1'b1);
        chk("wrap_sup", 32'(imem_req), 32'd0);
        run_cycle(1'b0, '0, 1'b1);
        chk("wrap_a0", imem_addr, 32'hFFFF_FFF8);
        run_cycle(1'b0, '0, 1'b1);
        chk("wrap_a1", imem_addr, 32'hFFFF_FFFC);
        run_cycle(1'b0, '0, 1'b1);
        chk("wrap_a2", imem_addr, 32'h0000_0000);
        chk_head("wrap_o0", 32'hFFFF_FFF8, 32'hFFFF_FFF8 ^ TAG, 1'b0);
        run_cycle(1'b0, '0, 1'b1);
        chk_head("wrap_o1", 32'hFFFF_FFFC, 32'hFFFF_FFFC ^ TAG, 1'b0);
        run_cycle(1'b0, '0, 1'b1);
        chk_head("wrap_o2", 32'h0000_0000, TAG, 1'b0);

        // Reset with a full queue.
        run_cycle(1'b0, '0, 1'b0);
        chk_head("mrst_q", 32'h4, 32'h4 ^ TAG, 1'b0);
        run_cycle(1'b0, '0, 1'b0);
        chk_head("mrst_full", 32'h4, 32'h4 ^ TAG, 1'b0);
        reset = 1'b0;
        #1;
        chk("mrst_vld",   32'(out_valid), 32'd0);
        chk("mrst_pc",    out_pc, 32'd0);
        chk("mrst_instr", out_instr, 32'd0);
        chk("mrst_fault", 32'(out_fault), 32'd0);
        chk("mrst_req",   32'(imem_req), 32'd0);
        run_cycle(1'b0, '0, 1'b1);
        chk("mrst_vld2", 32'(out_valid), 32'd0);
        chk("mrst_req2", 32'(imem_req),  32'd0);
        run_cycle(1'b0, '0, 1'b1);
        reset = 1'b1;
        #1;
        chk("rel_req",  32'(imem_req), 32'd1);
        chk("rel_addr", imem_addr, 32'd0);
        chk("rel_vld",  32'(out_valid), 32'd0);
        run_cycle(1'b0, '0, 1'b1);
        chk("rel_addr1", imem_addr, 32'd4);
        chk("rel_vld1",  32'(out_valid), 32'd0);
        run_cycle(1'b0, '0, 1'b1);
        chk("rel_addr2", imem_addr, 32'd8);
        chk_head("rel_o0", 32'd0, TAG, 1'b0);
        run_cycle(1'b0, '0, 1'b1);
        chk_head("rel_o1", 32'd4, 32'd4 ^ TAG, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
